// File: rtl/modmul_issuer.sv
`default_nettype none
// ============================================================================
// Module   : modmul_issuer
// Purpose  : Requester for a 256-bit modular multiplier that follows a
//            start/done protocol (single start pulse, sticky done, operands
//            held for the whole operation, re-armed only through its rst).
//            Operand pairs arrive on a valid/ready stream. They are issued to
//            the multiplier, and the product (or a timeout error) is returned
//            on a second valid/ready stream. After every operation the
//            multiplier receives a local reset pulse to re-arm it.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clock      in   1    system clock, rising edge
//   rst        in   1    synchronous active-high reset
//   in_valid   in   1    operand pair valid
//   in_ready   out  1    block can accept operands (state == IDLE)
//   in_x/in_y  in   256  operands
//   out_valid  out  1    result valid
//   out_ready  in   1    consumer accepts result
//   out_q      out  256  result, 0 on error
//   out_err    out  1    result is a timeout error
//   mm_rst     out  1    multiplier reset
//   mm_start   out  1    multiplier start pulse
//   mm_x/mm_y  out  256  multiplier operands
//   mm_q       in   256  multiplier result
//   mm_done    in   1    multiplier done (sticky until its rst)
//   busy       out  1    state != IDLE
//   op_count   out  16   completed operations including errors (wraps)
// ============================================================================
module modmul_issuer #(
  parameter int TIMEOUT_CYCLES = 255,  // 2..65535
  parameter int REARM_CYCLES   = 2     // >= 1
) (
  input  logic         clock,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] in_x,
  input  logic [255:0] in_y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [255:0] out_q,
  output logic         out_err,
  output logic         mm_rst,
  output logic         mm_start,
  output logic [255:0] mm_x,
  output logic [255:0] mm_y,
  input  logic [255:0] mm_q,
  input  logic         mm_done,
  output logic         busy,
  output logic [15:0]  op_count
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_ISSUE  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_RESP   = 3'd3;
  localparam logic [2:0] S_REARM  = 3'd4;
  localparam logic [2:0] S_SETTLE = 3'd5;

  // Last timer value still counted as a legal WAIT cycle; reaching it without
  // done means the multiplier has spent TIMEOUT_CYCLES cycles in WAIT.
  localparam logic [15:0] C_TIMEOUT_LAST = 16'(TIMEOUT_CYCLES - 1);
  localparam logic [15:0] C_REARM_LAST   = 16'(REARM_CYCLES - 1);

  logic [2:0]   r_state;
  logic [2:0]   w_next_state;
  logic [15:0]  r_timer;
  logic [15:0]  r_rearm_cnt;
  logic         r_mm_rst;
  logic         r_mm_start;
  logic [255:0] r_mm_x;
  logic [255:0] r_mm_y;
  logic         r_out_valid;
  logic [255:0] r_out_q;
  logic         r_out_err;
  logic [15:0]  r_op_count;
  logic         w_timeout;
  logic         w_rearm_last;

  assign w_timeout    = (r_timer == C_TIMEOUT_LAST);
  assign w_rearm_last = (r_rearm_cnt == C_REARM_LAST);

  // --------------------------------------------------------------------------
  // State register. Reset lands in REARM so the multiplier is re-armed before
  // the first operation, whatever state it was left in.
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      r_state <= S_REARM;
    end else begin
      r_state <= w_next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_next_state = S_ISSUE;
        end
      end
      S_ISSUE: begin
        w_next_state = S_WAIT;
      end
      S_WAIT: begin
        if (mm_done || w_timeout) begin
          w_next_state = S_RESP;
        end
      end
      S_RESP: begin
        if (out_ready) begin
          w_next_state = S_REARM;
        end
      end
      S_REARM: begin
        if (w_rearm_last) begin
          w_next_state = S_SETTLE;
        end
      end
      S_SETTLE: begin
        // A done still high here would belong to the previous operation;
        // hold off until the multiplier has dropped it.
        if (!mm_done) begin
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_REARM;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Combinational outputs
  // --------------------------------------------------------------------------
  always_comb begin
    in_ready = (r_state == S_IDLE);
    busy     = (r_state != S_IDLE);
  end

  // --------------------------------------------------------------------------
  // Registered datapath and multiplier controls
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (rst) begin
      r_mm_rst    <= 1'b1;
      r_mm_start  <= 1'b0;
      r_mm_x      <= '0;
      r_mm_y      <= '0;
      r_out_valid <= 1'b0;
      r_out_q     <= '0;
      r_out_err   <= 1'b0;
      r_op_count  <= '0;
      r_timer     <= '0;
      r_rearm_cnt <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_mm_rst <= 1'b0;
          if (in_valid) begin
            r_mm_x     <= in_x;
            r_mm_y     <= in_y;
            r_mm_start <= 1'b1;
          end
        end
        S_ISSUE: begin
          r_mm_start <= 1'b0;
          r_timer    <= '0;
        end
        S_WAIT: begin
          r_timer <= r_timer + 16'd1;
          // done takes priority over an expiring timer
          if (mm_done) begin
            r_out_q     <= mm_q;
            r_out_err   <= 1'b0;
            r_out_valid <= 1'b1;
          end else if (w_timeout) begin
            r_out_q     <= '0;
            r_out_err   <= 1'b1;
            r_out_valid <= 1'b1;
          end
        end
        S_RESP: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_op_count  <= r_op_count + 16'd1;
            r_rearm_cnt <= '0;
            r_mm_rst    <= 1'b1;
          end
        end
        S_REARM: begin
          r_mm_x      <= '0;
          r_mm_y      <= '0;
          r_rearm_cnt <= r_rearm_cnt + 16'd1;
          r_mm_rst    <= !w_rearm_last;
        end
        S_SETTLE: begin
          r_mm_rst <= 1'b0;
        end
        default: begin
          r_mm_rst <= 1'b1;
        end
      endcase
    end
  end

  assign mm_rst    = r_mm_rst;
  assign mm_start  = r_mm_start;
  assign mm_x      = r_mm_x;
  assign mm_y      = r_mm_y;
  assign out_valid = r_out_valid;
  assign out_q     = r_out_q;
  assign out_err   = r_out_err;
  assign op_count  = r_op_count;

endmodule
`default_nettype wire
